// File: rtl/uart_rx_flow_ctrl.sv
// uart_rx_flow_ctrl
// Receive-side flow-control buffer for the APB UART. Received characters
// (with their framing-error flag) are queued in a small show-ahead FIFO,
// and RTS (active low) is driven to the peer from the fill level with
// hysteresis. A character arriving while the FIFO is full is dropped and
// raises the sticky overrun flag.
//
// Ports:
//   clk, reset_n            - clock, synchronous active-low reset
//   rx_valid/rx_data/
//   rx_frame_err            - character from the UART receiver (1-cycle pulse)
//   rd_en                   - pop head entry (1-cycle pulse)
//   flow_en                 - 1 = hardware flow control, 0 = rts held at 0
//   clr_err                 - clear overrun_err
//   rd_data/rd_err          - head-of-FIFO entry (don't-care when empty)
//   rx_empty/rx_full        - registered FIFO status
//   rx_count                - fill level 0..DEPTH
//   rts                     - Request-To-Send to the peer, active low
//   overrun_err             - sticky: character dropped on full FIFO
module uart_rx_flow_ctrl #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int RTS_OFF_LVL = 12,
  parameter int RTS_ON_LVL  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_valid,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_frame_err,
  input  logic                     rd_en,
  input  logic                     flow_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  output logic                     rx_empty,
  output logic                     rx_full,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     rts,
  output logic                     overrun_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] OFF_LVL_C = CW'(RTS_OFF_LVL);
  localparam logic [CW-1:0] ON_LVL_C  = CW'(RTS_ON_LVL);

  typedef enum logic {
    RTS_ON  = 1'b0,
    RTS_OFF = 1'b1
  } rts_state_e;

  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic            rts_q, rts_d;
  rts_state_e      state_q, state_d;
  logic            do_wr_s, do_rd_s, ovr_set_s;
  logic [DATA_W:0] head_s;

  // Next-state logic: push/pop qualification, count, status, overrun and RTS.
  always_comb begin
    do_rd_s   = rd_en & ~empty_q;
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    do_wr_s   = rx_valid & (~full_q | do_rd_s);
    ovr_set_s = rx_valid & full_q & ~rd_en;

    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == DEPTH_C);

    // Set has priority over clear.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    // Hysteresis on the post-update count so rts moves on the crossing edge.
    if (count_d >= OFF_LVL_C) begin
      state_d = RTS_OFF;
    end else if (count_d <= ON_LVL_C) begin
      state_d = RTS_ON;
    end else begin
      state_d = state_q;
    end

    // The state keeps tracking fill level even while flow control is off.
    if (flow_en) begin
      rts_d = (state_d == RTS_OFF);
    end else begin
      rts_d = 1'b0;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= {rx_frame_err, rx_data};
    end
  end

  // Control registers with synchronous active-low reset (rts idles de-asserted).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= RTS_OFF;
      rts_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      rts_q     <= rts_d;
    end
  end

  assign head_s      = mem_q[rd_ptr_q];
  assign rd_data     = head_s[DATA_W-1:0];
  assign rd_err      = head_s[DATA_W];
  assign rx_empty    = empty_q;
  assign rx_full     = full_q;
  assign rx_count    = count_q;
  assign rts         = rts_q;
  assign overrun_err = overrun_q;

endmodule
